// File: rtl/pong_game_renderer.sv
// Pong game state plus block renderer. The game advances once per frame, and
// the colour and linear address of the 20x20 block under (hc, vc) are
// produced one cycle later for the frame double buffer.
module pong_game_renderer #(
   parameter int unsigned BLOCKING_FACTOR = 20,
   parameter int unsigned MOVE_DIV        = 4,
   parameter int unsigned PADDLE_H        = 4,
   parameter int unsigned SERVE_FRAMES    = 60,
   parameter int unsigned POINT_FRAMES    = 30,
   parameter int unsigned WIN_SCORE       = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  hc,
   input  logic [9:0]  vc,
   input  logic        btn_l_up,
   input  logic        btn_l_dn,
   input  logic        btn_r_up,
   input  logic        btn_r_dn,
   input  logic        btn_start,
   output logic [11:0] colorIn,
   output logic [9:0]  writeAddress,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r,
   output logic        game_over
);

   localparam int unsigned COLS     = 32;
   localparam int unsigned ROWS     = 24;
   localparam int unsigned H_ACT    = COLS * BLOCKING_FACTOR;
   localparam int unsigned V_ACT    = ROWS * BLOCKING_FACTOR;
   localparam int unsigned CW       = 8;
   localparam int unsigned PAD_MAX  = ROWS - PADDLE_H;
   localparam int unsigned PAD_INIT = 10;
   localparam int unsigned BALL_X0  = 16;
   localparam int unsigned BALL_Y0  = 12;
   localparam int unsigned L_COL    = 1;
   localparam int unsigned R_COL    = 30;
   localparam int unsigned MID_COL  = 16;
   localparam int unsigned L_HIT_X  = L_COL + 1;
   localparam int unsigned R_HIT_X  = R_COL - 1;

   typedef enum logic [1:0] {SERVE, PLAY, POINT, GAME_OVER} phase_t;

   phase_t          state;
   logic [CW-1:0]   frame_cnt;
   logic [CW-1:0]   phase_cnt;
   logic            prev_origin;
   logic [4:0]      bx, by, lp, rp;
   logic            dx_neg, dy_neg;

   logic            origin_c, frame_tick_c, move_tick_c, active_c;
   logic [4:0]      col_c, row_c;
   logic            ball_c, pad_c, mid_c;
   logic [11:0]     color_c;
   logic [4:0]      lp_nxt, rp_nxt, bx_nxt, by_nxt;
   logic            dx_nxt, dy_nxt;

   // True when row y lies within the paddle whose top row is top.
   function automatic logic in_span(input logic [4:0] y, input logic [4:0] top);
      return (y >= top) && (6'(y) <= 6'(top) + 6'(PADDLE_H - 1));
   endfunction

   // One paddle step: a single pressed button moves it, saturating at the edges.
   function automatic logic [4:0] pad_step(input logic [4:0] top, input logic up,
                                           input logic dn);
      logic [4:0] res;
      res = top;
      if (up && !dn && top != 5'd0)
         res = top - 5'd1;
      else if (dn && !up && top < 5'(PAD_MAX))
         res = top + 5'd1;
      return res;
   endfunction

   // Frame and movement tick detection.
   always_comb begin
      origin_c     = (hc == 10'd0) && (vc == 10'd0);
      frame_tick_c = origin_c && !prev_origin;
      move_tick_c  = frame_tick_c && (frame_cnt == CW'(MOVE_DIV - 1));
   end

   // Block lookup and colour priority for the current scan position.
   always_comb begin
      active_c = (hc < 10'(H_ACT)) && (vc < 10'(V_ACT));
      col_c    = 5'(hc / 10'(BLOCKING_FACTOR));
      row_c    = 5'(vc / 10'(BLOCKING_FACTOR));
      ball_c   = (state != GAME_OVER) && (col_c == bx) && (row_c == by);
      pad_c    = ((col_c == 5'(L_COL)) && in_span(row_c, lp)) ||
                 ((col_c == 5'(R_COL)) && in_span(row_c, rp));
      mid_c    = (col_c == 5'(MID_COL)) && !row_c[0];
      color_c  = (state == GAME_OVER) ? 12'h400 : 12'h000;
      if (ball_c)
         color_c = 12'hF00;
      else if (pad_c)
         color_c = 12'hFFF;
      else if (mid_c)
         color_c = 12'h444;
   end

   // Candidate paddle and ball positions for a movement tick.
   always_comb begin
      lp_nxt = pad_step(lp, btn_l_up, btn_l_dn);
      rp_nxt = pad_step(rp, btn_r_up, btn_r_dn);
      dy_nxt = dy_neg;
      if (by == 5'd0 && dy_neg)
         dy_nxt = 1'b0;
      else if (by == 5'(ROWS - 1) && !dy_neg)
         dy_nxt = 1'b1;
      dx_nxt = dx_neg;
      if (bx == 5'(L_HIT_X) && dx_neg && in_span(by, lp_nxt))
         dx_nxt = 1'b0;
      else if (bx == 5'(R_HIT_X) && !dx_neg && in_span(by, rp_nxt))
         dx_nxt = 1'b1;
      bx_nxt = dx_nxt ? bx - 5'd1 : bx + 5'd1;
      by_nxt = dy_nxt ? by - 5'd1 : by + 5'd1;
   end

   // Game phase FSM, per-frame state updates and registered render outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= SERVE;
         frame_cnt    <= '0;
         phase_cnt    <= '0;
         prev_origin  <= 1'b0;
         bx           <= 5'(BALL_X0);
         by           <= 5'(BALL_Y0);
         dx_neg       <= 1'b0;
         dy_neg       <= 1'b0;
         lp           <= 5'(PAD_INIT);
         rp           <= 5'(PAD_INIT);
         score_l      <= 4'd0;
         score_r      <= 4'd0;
         game_over    <= 1'b0;
         colorIn      <= 12'h000;
         writeAddress <= 10'd0;
      end else begin
         prev_origin <= origin_c;

         if (active_c) begin
            colorIn      <= color_c;
            writeAddress <= {row_c, col_c};
         end else begin
            colorIn      <= 12'h000;
         end

         if (frame_tick_c) begin
            frame_cnt <= move_tick_c ? '0 : frame_cnt + CW'(1);
            case (state)
               SERVE: begin
                  bx <= 5'(BALL_X0);
                  by <= 5'(BALL_Y0);
                  if (move_tick_c) begin
                     lp <= lp_nxt;
                     rp <= rp_nxt;
                  end
                  if (phase_cnt == CW'(SERVE_FRAMES - 1)) begin
                     phase_cnt <= '0;
                     state     <= PLAY;
                  end else begin
                     phase_cnt <= phase_cnt + CW'(1);
                  end
               end
               PLAY: begin
                  if (move_tick_c) begin
                     lp     <= lp_nxt;
                     rp     <= rp_nxt;
                     bx     <= bx_nxt;
                     by     <= by_nxt;
                     dx_neg <= dx_nxt;
                     dy_neg <= dy_nxt;
                     if (bx_nxt == 5'd0) begin
                        score_r   <= (score_r == 4'd15) ? score_r : score_r + 4'd1;
                        phase_cnt <= '0;
                        state     <= POINT;
                     end else if (bx_nxt == 5'(COLS - 1)) begin
                        score_l   <= (score_l == 4'd15) ? score_l : score_l + 4'd1;
                        phase_cnt <= '0;
                        state     <= POINT;
                     end
                  end
               end
               POINT: begin
                  if (phase_cnt == CW'(POINT_FRAMES - 1)) begin
                     phase_cnt <= '0;
                     if (score_l == 4'(WIN_SCORE) || score_r == 4'(WIN_SCORE)) begin
                        state     <= GAME_OVER;
                        game_over <= 1'b1;
                     end else begin
                        state  <= SERVE;
                        bx     <= 5'(BALL_X0);
                        by     <= 5'(BALL_Y0);
                        dy_neg <= 1'b0;
                        // Serve toward whoever just missed.
                        dx_neg <= (bx == 5'd0);
                     end
                  end else begin
                     phase_cnt <= phase_cnt + CW'(1);
                  end
               end
               GAME_OVER: begin
                  if (btn_start) begin
                     score_l   <= 4'd0;
                     score_r   <= 4'd0;
                     lp        <= 5'(PAD_INIT);
                     rp        <= 5'(PAD_INIT);
                     bx        <= 5'(BALL_X0);
                     by        <= 5'(BALL_Y0);
                     phase_cnt <= '0;
                     state     <= SERVE;
                     game_over <= 1'b0;
                  end
               end
               default: state <= SERVE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pong_game_renderer.sv
// Directed bench for pong_game_renderer: frames are compressed to a short
// origin pulse followed by one off-screen cycle, and single blocks are probed.
module tb_pong_game_renderer;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  hc, vc;
   logic        btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, btn_start;
   logic [11:0] colorIn;
   logic [9:0]  writeAddress;
   logic [3:0]  score_l, score_r;
   logic        game_over;

   int checks = 0;
   int errors = 0;
   int fr     = 0;

   pong_game_renderer dut (
      .clk          (clk),
      .rst          (rst),
      .hc           (hc),
      .vc           (vc),
      .btn_l_up     (btn_l_up),
      .btn_l_dn     (btn_l_dn),
      .btn_r_up     (btn_r_up),
      .btn_r_dn     (btn_r_dn),
      .btn_start    (btn_start),
      .colorIn      (colorIn),
      .writeAddress (writeAddress),
      .score_l      (score_l),
      .score_r      (score_r),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive the centre of block (c, r) for one cycle and check the rendered result.
   task automatic probe(input int c, input int r, input logic [11:0] exp_col, input string tag);
      hc = 10'(c * 20 + 10);
      vc = 10'(r * 20 + 10);
      @(posedge clk); #1;
      check({tag, "_col"}, 16'(colorIn), 16'(exp_col));
      check({tag, "_adr"}, 16'(writeAddress), 16'(r * 32 + c));
      hc = 10'd700;
      vc = 10'd500;
   endtask

   // One frame: origin held for 'hold' cycles, then one off-screen cycle.
   task automatic frame(input int hold);
      hc = 10'd0;
      vc = 10'd0;
      repeat (hold) @(posedge clk);
      #1;
      hc = 10'd700;
      vc = 10'd500;
      @(posedge clk); #1;
      fr++;
   endtask

   task automatic run_to(input int n);
      while (fr < n) frame(1);
   endtask

   initial begin
      rst = 1'b1; hc = 10'd700; vc = 10'd500;
      btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0; btn_r_dn = 0; btn_start = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_color", 16'(colorIn), 16'h000);
      check("rst_addr", 16'(writeAddress), 16'd0);
      check("rst_score_l", 16'(score_l), 16'd0);
      check("rst_score_r", 16'(score_r), 16'd0);
      check("rst_game_over", 16'(game_over), 16'd0);

      // Initial picture.
      probe(16, 12, 12'hF00, "init_ball");
      probe(1, 10, 12'hFFF, "init_lp10");
      probe(1, 11, 12'hFFF, "init_lp11");
      probe(1, 12, 12'hFFF, "init_lp12");
      probe(1, 13, 12'hFFF, "init_lp13");
      probe(30, 10, 12'hFFF, "init_rp10");
      probe(16, 0, 12'h444, "init_mid0");
      probe(16, 1, 12'h000, "init_mid1");
      probe(0, 0, 12'h000, "init_bg0");

      // Latency, off-screen hold and the last active pixel.
      hc = 10'd40; vc = 10'd60;
      @(posedge clk); #1;
      check("lat_addr", 16'(writeAddress), 16'd98);
      check("lat_col", 16'(colorIn), 16'h000);
      hc = 10'd330; vc = 10'd250;
      @(posedge clk); #1;
      check("lat2_col", 16'(colorIn), 16'hF00);
      check("lat2_addr", 16'(writeAddress), 16'd400);
      hc = 10'd700; vc = 10'd250;
      @(posedge clk); #1;
      check("offh_col", 16'(colorIn), 16'h000);
      check("offh_addr", 16'(writeAddress), 16'd400);
      hc = 10'd30; vc = 10'd480;
      @(posedge clk); #1;
      check("offv_col", 16'(colorIn), 16'h000);
      check("offv_addr", 16'(writeAddress), 16'd400);
      hc = 10'd639; vc = 10'd479;
      @(posedge clk); #1;
      check("last_col", 16'(colorIn), 16'h000);
      check("last_addr", 16'(writeAddress), 16'd767);

      // Left paddle up; the first frames hold the origin for 3 cycles.
      btn_l_up = 1;
      repeat (4) frame(3);
      run_to(36);
      probe(1, 0, 12'h000, "lp1_r0");
      probe(1, 1, 12'hFFF, "lp1_r1");
      probe(1, 4, 12'hFFF, "lp1_r4");
      probe(1, 5, 12'h000, "lp1_r5");
      run_to(44);
      probe(1, 0, 12'hFFF, "lp0_r0");
      probe(1, 3, 12'hFFF, "lp0_r3");
      probe(1, 4, 12'h000, "lp0_r4");
      btn_l_up = 0;

      // Both right buttons: no movement.
      btn_r_up = 1; btn_r_dn = 1;
      run_to(48);
      probe(30, 9, 12'h000, "rboth_r9");
      probe(30, 10, 12'hFFF, "rboth_r10");
      probe(30, 13, 12'hFFF, "rboth_r13");
      probe(30, 14, 12'h000, "rboth_r14");
      btn_r_up = 0;

      // Right paddle down during serve; ball held at centre.
      run_to(60);
      probe(16, 12, 12'hF00, "serve_ball");
      probe(30, 12, 12'h000, "rp13_r12");
      probe(30, 16, 12'hFFF, "rp13_r16");
      run_to(64);
      probe(17, 13, 12'hF00, "play_k1");
      probe(16, 12, 12'h444, "play_mid12");
      run_to(96);
      probe(30, 19, 12'h000, "rp20_r19");
      probe(30, 20, 12'hFFF, "rp20_r20");
      probe(30, 23, 12'hFFF, "rp20_r23");
      run_to(104);
      probe(27, 23, 12'hF00, "ball_bottom");
      run_to(108);
      probe(28, 22, 12'hF00, "ball_wall_bounce");
      run_to(116);
      probe(28, 20, 12'hF00, "ball_rpad_bounce");
      btn_r_dn = 0;

      // Ball returns left past the raised left paddle and the right player scores.
      run_to(224);
      probe(1, 7, 12'hF00, "ball_k41");
      check("score_r_before", 16'(score_r), 16'd0);
      run_to(228);
      probe(0, 8, 12'hF00, "ball_miss");
      check("score_r_point", 16'(score_r), 16'd1);
      check("score_l_point", 16'(score_l), 16'd0);

      // Point pause: ball and paddles frozen, then serve toward the left.
      btn_l_dn = 1;
      run_to(257);
      probe(0, 8, 12'hF00, "point_frozen");
      probe(1, 0, 12'hFFF, "point_lp_frozen");
      run_to(258);
      probe(16, 12, 12'hF00, "reserve_ball");
      run_to(320);
      probe(15, 13, 12'hF00, "serve_left_k1");
      run_to(376);
      probe(3, 19, 12'hF00, "ball_lpad_bounce");
      btn_l_dn = 0;
      btn_r_up = 1;
      run_to(487);
      check("score_l_before", 16'(score_l), 16'd0);
      run_to(488);
      check("score_l_first", 16'(score_l), 16'd1);

      // Left keeps scoring until the winning point.
      while (score_l != 4'd9 && fr < 3000) frame(1);
      check("score_l_win", 16'(score_l), 16'd9);
      check("score_r_win", 16'(score_r), 16'd1);
      btn_r_up = 0;
      repeat (29) frame(1);
      check("go_before", 16'(game_over), 16'd0);
      frame(1);
      check("go_set", 16'(game_over), 16'd1);
      probe(31, 19, 12'h400, "go_ball_hidden");
      probe(5, 5, 12'h400, "go_bg");
      probe(1, 20, 12'hFFF, "go_lpad");
      probe(16, 0, 12'h444, "go_mid");

      // Start only counts when sampled at a frame tick.
      btn_start = 1;
      probe(5, 6, 12'h400, "go_start_midframe");
      btn_start = 0;
      check("go_hold1", 16'(game_over), 16'd1);
      frame(1);
      check("go_hold2", 16'(game_over), 16'd1);
      btn_start = 1;
      frame(3);
      btn_start = 0;
      check("restart_go", 16'(game_over), 16'd0);
      check("restart_sl", 16'(score_l), 16'd0);
      check("restart_sr", 16'(score_r), 16'd0);
      probe(1, 9, 12'h000, "restart_lp9");
      probe(1, 10, 12'hFFF, "restart_lp10");
      probe(30, 10, 12'hFFF, "restart_rp10");
      probe(16, 12, 12'hF00, "restart_ball");
      probe(5, 5, 12'h000, "restart_bg");

      // Mid-frame reset clears the registered outputs on the next edge.
      hc = 10'd330; vc = 10'd250; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst2_color", 16'(colorIn), 16'h000);
      check("rst2_addr", 16'(writeAddress), 16'd0);
      check("rst2_go", 16'(game_over), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
